// File: rtl/alu_mdu_if.sv
// Execute-stage operand/result bundle for alu_mdu; ovf exists only when ALU_OVF_EN is defined.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       ALUOp;
    logic [SW-1:0]    shamt;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef ALU_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_a, in_b, ALUOp, shamt, start,
        input  result, zero, busy, hi, lo
`ifdef ALU_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_a, in_b, ALUOp, shamt, start,
        output result, zero, busy, hi, lo
`ifdef ALU_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/alu_mdu.sv
// EX-stage ALU (combinational) plus multi-cycle multiply/divide unit with HI/LO.
// Define ALU_OVF_EN to add the signed ADD/SUB overflow flag.
module alu_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    alu_mdu_if.slave   bus
);
    localparam int MSB  = WIDTH - 1;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MTHI  = 4'b1010;
    localparam logic [3:0] OP_MTLO  = 4'b1011;
    localparam logic [3:0] OP_SRA   = 4'b1100;
    localparam logic [3:0] OP_SRL   = 4'b1101;
    localparam logic [3:0] OP_XOR   = 4'b1110;
    localparam logic [3:0] OP_SLL   = 4'b1111;

    typedef enum logic {IDLE, RUN} state_t;

    logic [WIDTH-1:0] a, b, res;
    assign a = bus.in_a;
    assign b = bus.in_b;

    always_comb begin
        res = '0;
        case (bus.ALUOp)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = b << bus.shamt;
            OP_SRL:  res = b >> bus.shamt;
            OP_SRA:  res = $signed(b) >>> bus.shamt;
            OP_SLT:  res = {{MSB{1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: res = {{MSB{1'b0}}, a < b};
            default: res = '0;
        endcase
    end

    assign bus.result = res;
    assign bus.zero   = (res == '0);

`ifdef ALU_OVF_EN
    // Signed overflow shows up as a result sign that disagrees with in_a.
    assign bus.ovf = ((bus.ALUOp == OP_ADD) && (a[MSB] == b[MSB]) && (res[MSB] != a[MSB])) ||
                     ((bus.ALUOp == OP_SUB) && (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]));
`endif

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic             sgn_q, div_q, busy_q;

    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   ua, ub, uq, ur, quo_d, rem_d;
    logic               a_neg, b_neg;

    always_comb begin
        if (sgn_q)
            prod_d = {{WIDTH{a_q[MSB]}}, a_q} * {{WIDTH{b_q[MSB]}}, b_q};
        else
            prod_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end

    // Divide on magnitudes; the MIN/-1 case falls out as MIN with zero remainder.
    always_comb begin
        a_neg = sgn_q & a_q[MSB];
        b_neg = sgn_q & b_q[MSB];
        ua    = a_neg ? -a_q : a_q;
        ub    = b_neg ? -b_q : b_q;
        uq    = (ub == '0) ? '0 : ua / ub;
        ur    = (ub == '0) ? '0 : ua % ub;
        quo_d = (a_neg ^ b_neg) ? -uq : uq;
        rem_d = a_neg ? -ur : ur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.ALUOp)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                                a_q     <= a;
                                b_q     <= b;
                                sgn_q   <= (bus.ALUOp == OP_MULT) || (bus.ALUOp == OP_DIV);
                                div_q   <= (bus.ALUOp == OP_DIV)  || (bus.ALUOp == OP_DIVU);
                                cnt_q   <= ((bus.ALUOp == OP_DIV) || (bus.ALUOp == OP_DIVU)) ?
                                           CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (!div_q) begin
                            {hi_q, lo_q} <= prod_d;
                        end else if (b_q != '0) begin
                            hi_q <= rem_d;
                            lo_q <= quo_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_alu_mdu;
    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W)) bus();
    alu_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit          alu;
        logic [31:0] res;
        bit          zero;
        bit          ovf;
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } now_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
        string       nm;
    } com_t;

    now_t now_q[$];
    com_t com_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    bit   aborted = 0;

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b, int sh);
        case (op)
            4'b0010: return 32'(longint'(a) + longint'(b));
            4'b0110: return 32'(longint'(a) - longint'(b));
            4'b0001: return a | b;
            4'b0000: return a & b;
            4'b1110: return a ^ b;
            4'b1111: return b << sh;
            4'b1101: return b >> sh;
            4'b1100: return 32'(int'(b) >>> sh);
            4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b1000: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ovf_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint s;
        if (op == 4'b0010)      s = longint'(int'(a)) + longint'(int'(b));
        else if (op == 4'b0110) s = longint'(int'(a)) - longint'(int'(b));
        else return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_chk(logic [3:0] op, logic [31:0] a, logic [31:0] b, int sh, string nm);
        now_t c;
        bus.ALUOp = op; bus.in_a = a; bus.in_b = b; bus.shamt = sh[4:0]; bus.start = 1'b0;
        c.alu = 1; c.res = alu_ref(op, a, b, sh); c.zero = (c.res == 0);
        c.ovf = ovf_ref(op, a, b); c.hi = 0; c.lo = 0; c.nm = nm;
        now_q.push_back(c);
        tick();
    endtask

    task automatic push_regs(string nm);
        now_t c;
        c.alu = 0; c.res = 0; c.zero = 0; c.ovf = 0; c.hi = m_hi; c.lo = m_lo; c.nm = nm;
        now_q.push_back(c);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 100) begin
            tick();
            k++;
        end
        n_cmp++;
        if (bus.busy) begin
            n_err++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", k);
        end
    endtask

    task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b, string nm);
        com_t   c;
        longint p, q, r;
        bit     reg_op = 0;
        wait_idle();
        bus.ALUOp = op; bus.in_a = a; bus.in_b = b; bus.shamt = 0; bus.start = 1'b1;
        c.nm = nm; c.n = DC;
        case (op)
            4'b0011: begin p = longint'(int'(a)) * longint'(int'(b)); c.n = MC;
                           m_hi = p[63:32]; m_lo = p[31:0]; end
            4'b0100: begin p = longint'(a) * longint'(b); c.n = MC;
                           m_hi = p[63:32]; m_lo = p[31:0]; end
            4'b0101: if (b != 0) begin
                         q = longint'(int'(a)) / longint'(int'(b));
                         r = longint'(int'(a)) % longint'(int'(b));
                         m_hi = r[31:0]; m_lo = q[31:0];
                     end
            4'b1001: if (b != 0) begin
                         q = longint'(a) / longint'(b);
                         r = longint'(a) % longint'(b);
                         m_hi = r[31:0]; m_lo = q[31:0];
                     end
            4'b1010: begin m_hi = a; reg_op = 1; end
            default: begin m_lo = a; reg_op = 1; end
        endcase
        c.hi = m_hi; c.lo = m_lo;
        if (!reg_op) com_q.push_back(c);
        tick();
        bus.start = 1'b0;
        bus.in_a = $urandom();
        bus.in_b = $urandom();
        if (reg_op) push_regs(nm);
    endtask

    // Monitor: immediate checks plus commit checks when busy falls.
    int busy_cycles = 0;
    bit prev_busy = 0;
    always @(negedge clk) begin
        if (now_q.size() > 0) begin
            now_t c;
            c = now_q.pop_front();
            if (c.alu) begin
                cmp({c.nm, " result"}, 64'(bus.result), 64'(c.res));
                cmp({c.nm, " zero"}, 64'(bus.zero), 64'(c.zero));
`ifdef ALU_OVF_EN
                cmp({c.nm, " ovf"}, 64'(bus.ovf), 64'(c.ovf));
`endif
            end else begin
                cmp({c.nm, " hi"}, 64'(bus.hi), 64'(c.hi));
                cmp({c.nm, " lo"}, 64'(bus.lo), 64'(c.lo));
                cmp({c.nm, " busy"}, 64'(bus.busy), 64'd0);
            end
        end
        if (bus.busy) begin
            busy_cycles++;
        end else if (prev_busy) begin
            if (aborted) begin
                aborted = 0;
            end else if (com_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_commit: busy fell with nothing outstanding");
            end else begin
                com_t c;
                c = com_q.pop_front();
                cmp({c.nm, " hi"}, 64'(bus.hi), 64'(c.hi));
                cmp({c.nm, " lo"}, 64'(bus.lo), 64'(c.lo));
                cmp({c.nm, " busy_cycles"}, 64'(busy_cycles), 64'(c.n));
            end
            busy_cycles = 0;
        end
        prev_busy = bus.busy;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    localparam logic [3:0] MDU_OPS [6] = '{4'b0011, 4'b0100, 4'b0101, 4'b1001, 4'b1010, 4'b1011};

    initial begin
        logic [31:0] a, b;
        logic [3:0]  op;
        int          sel;
        bus.in_a = 0; bus.in_b = 0; bus.ALUOp = 0; bus.shamt = 0; bus.start = 0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        push_regs("reset_state");
        tick();

        alu_chk(4'b0010, 32'h7FFFFFFF, 32'h1, 0, "add_max");
        alu_chk(4'b0110, 32'd5, 32'd5, 0, "sub_zero");
        alu_chk(4'b1100, 32'h0, 32'h80000000, 4, "sra_neg");
        alu_chk(4'b0111, 32'hFFFFFFFF, 32'h1, 0, "slt_neg");
        alu_chk(4'b1000, 32'hFFFFFFFF, 32'h1, 0, "sltu_neg");
        alu_chk(4'b1010, 32'h1234, 32'h5678, 3, "unused_1010");
        alu_chk(4'b0110, 32'h80000000, 32'h1, 0, "sub_min");
        alu_chk(4'b0010, 32'h1, 32'h1, 0, "add_small");
        alu_chk(4'b1111, 32'h0, 32'h80000001, 31, "sll_31");
        alu_chk(4'b1101, 32'h0, 32'h80000000, 31, "srl_31");

        issue(4'b0011, -32'sd3, 32'sd7, "mult_m3x7");
        issue(4'b0101, -32'sd7, 32'sd2, "div_m7by2");
        issue(4'b1001, 32'd7, 32'd0, "divu_by0");
        issue(4'b0101, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        issue(4'b1010, 32'hCAFEF00D, 32'h0, "mthi");
        issue(4'b1011, 32'h0BADBEEF, 32'h0, "mtlo");

        // Starts while busy must be dropped; ALU stays live.
        issue(4'b0100, 32'hDEADBEEF, 32'h00012345, "multu_busy");
        bus.ALUOp = 4'b1001; bus.in_a = 32'd99; bus.in_b = 32'd3; bus.start = 1'b1;
        tick();
        bus.ALUOp = 4'b1011; bus.in_a = 32'h1234; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        alu_chk(4'b1110, 32'hF0F0F0F0, 32'h0FF00FF0, 0, "xor_during_busy");
        wait_idle();
        tick();
        push_regs("after_ignored_starts");
        tick();

        // Reset in the middle of a divide.
        issue(4'b0101, 32'd1000, 32'd7, "div_reset");
        tick();
        tick();
        aborted = 1;
        com_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        push_regs("mid_div_reset");
        tick();
        issue(4'b0100, 32'hFFFFFFFF, 32'h2, "multu_after_reset");

        for (int i = 0; i < 150; i++) begin
            a = $urandom(); b = ($urandom_range(0, 7) == 0) ? a : $urandom();
            alu_chk(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 31), "rand_alu");
        end

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            op  = MDU_OPS[sel];
            a   = $urandom();
            b   = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 17));
                default: ;
            endcase
            issue(op, a, b, "rand_mdu");
        end

        wait_idle();
        repeat (3) tick();
        n_cmp++;
        if (com_q.size() != 0 || now_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d commits and %0d checks outstanding, required 0",
                     com_q.size(), now_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Next-generation execute-stage arithmetic unit for the pipelined CPU.
- Widens the single-cycle ALU to a parameterised data width and adds shifts and set-less-than.
- Adds a multi-cycle multiply/divide unit with HI/LO registers and a busy handshake.
- Sits in the EX stage: the ALU result is combinational; MDU results appear on hi/lo after a fixed latency.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, power of two).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_a  input  WIDTH  operand A (rs)
- in_b  input  WIDTH  operand B (rt/imm)
- ALUOp  input  4  operation select
- shamt  input  $clog2(WIDTH)  shift amount
- start  input  1  launch the MDU op on ALUOp this cycle
- result  output  WIDTH  combinational ALU result
- zero  output  1  result == 0
- busy  output  1  MDU in progress
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Combinational ALU ops (result is valid in the same cycle, independent of busy):
  - 0010 ADD, in_a+in_b, wraps mod 2^WIDTH.
  - 0110 SUB, in_a-in_b, wraps.
  - 0001 OR.
  - 0000 AND.
  - 1110 XOR.
  - 1111 SLL, in_b<<shamt.
  - 1101 SRL, logical in_b>>shamt.
  - 1100 SRA, arithmetic in_b>>>shamt.
  - 0111 SLT, signed compare, result {0..,1} or 0.
  - 1000 SLTU, unsigned compare.
  - Any other code gives result=0.
- zero = (result==0).
- MDU ops act only when start=1 at a rising edge with busy=0 and reset=0; otherwise they are ignored:
  - 0011 MULT, signed: {hi,lo} <= in_a*in_b.
  - 0100 MULTU, unsigned: {hi,lo} <= in_a*in_b.
  - 0101 DIV, signed: lo <= quotient truncated toward zero; hi <= remainder with the sign of the dividend.
  - 1001 DIVU, unsigned: lo <= quotient; hi <= remainder.
  - 1010 MTHI: hi <= in_a at that edge; busy stays 0.
  - 1011 MTLO: lo <= in_a at that edge; busy stays 0.
  - start=1 with a non-MDU ALUOp: no MDU effect.
- Operands are latched at the accepting edge; later changes to in_a/in_b have no effect.
- Latency: after the accepting edge E, busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). At edge E+N, hi/lo update and busy falls on that same edge. hi/lo hold their old values while busy.
- FSM:
  - IDLE -> RUN on an accepted MULT/MULTU/DIV/DIVU; the down-counter loads N-1.
  - RUN decrements each edge.
  - RUN -> IDLE when the counter is 0: commit hi/lo.
- Divide by zero (in_b==0 at accept): runs the full DIV_CYCLES busy period, then hi/lo are left unchanged.
- Signed overflow case (DIV of -2^(WIDTH-1) by -1): lo=-2^(WIDTH-1), hi=0.
- start while busy: ignored entirely (no queueing, including MTHI/MTLO).
- Back-to-back: a start in the cycle after busy falls is accepted normally.
- Reset (any cycle, including mid-operation): hi=0, lo=0, busy=0, state IDLE, counter 0; the pending result is discarded.
- result/zero are purely combinational and have no reset value.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, combinational).
  - ovf=1 when ADD or SUB overflows as a signed operation (operands with matching signs for ADD, or differing signs for SUB, and the result sign differs from in_a).
  - ovf=0 for all other ops.
- Undefined: the port does not exist; ADD/SUB silently wrap.

Test Plan:
- ALU sweep, WIDTH=32:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, zero=0.
  - SUB 5-5 -> 0, zero=1.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLT -1<1 -> 1; SLTU -1<1 -> 0.
  - Unused code 1010 with start=0 -> 0.
- MULT -3*7 with start at edge E:
  - busy=1 for cycles E..E+4.
  - At edge E+5: hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles. DIVU 7/0 -> hi/lo keep their prior values after 10 busy cycles.
- During MULTU busy, pulse start with DIVU and with MTLO 0x1234 -> both ignored. The final lo equals the MULTU low word.
- Assert reset at cycle 3 of a DIV -> next edge hi=lo=0, busy=0. A new MULTU 0xFFFFFFFF*2 then gives hi=1, lo=0xFFFFFFFE.
- With ALU_OVF_EN: ADD 0x7FFFFFFF+1 -> ovf=1; SUB 0x80000000-1 -> ovf=1; ADD 1+1 -> ovf=0.
